approx_err_monitor: RTL and testbench

Sequential error-characterization engine for the approximate recursive multipliers. It accepts a stream of (a, b, approximate product) samples over a valid/ready handshake. For each sample it computes the exact product internally and accumulates accuracy statistics: total samples, exact matches, summed error distance, and worst-case error with its operands. It sits on the output side of any approximate multiplier under test and turns the exhaustive accuracy check into synthesizable hardware for on-chip or FPGA characterization.

---
 rtl/approx_err_monitor_pkg.sv | 21 ++
 rtl/approx_err_monitor_exact_mult.sv | 17 +
 rtl/approx_err_monitor.sv | 252 +++++++++++++++++++++++++
 tb/tb_approx_err_monitor.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_err_monitor_pkg.sv
// approx_err_monitor_pkg
//   Shared definitions for the approximate-multiplier error monitors:
//   default operand/counter widths, FSM state encoding and the drain length
//   of the two-stage statistics pipeline.
package approx_err_monitor_pkg;

    localparam int unsigned DEF_W     = 4;
    localparam int unsigned DEF_CNT_W = 16;

    // Edges between the acceptance of the last sample and done.
    localparam int unsigned DRAIN_LAT = 2;
    localparam logic [1:0]  DRAIN_LOAD = 2'(DRAIN_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/approx_err_monitor_exact_mult.sv
// exact_mult
//   Combinational unsigned W x W multiplier giving the full 2W-bit product.
//   Serves as the reference against which the approximate product is judged.
// Ports:
//   a, b : W-bit unsigned operands
//   p    : 2W-bit exact product
module exact_mult #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b};

endmodule

// File: rtl/approx_err_monitor.sv
// approx_err_monitor
//   Streams (a, b, approximate product) samples over valid/ready and keeps
//   accuracy statistics: sample count, exact-match count, summed error
//   distance and the worst error distance together with its operands.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : clears statistics and begins a run (IDLE/DONE only)
//   in_valid / in_ready   : sample handshake; in_ready is high only in RUN
//   in_a, in_b, in_y      : operands and approximate product under test
//   in_last               : final sample of the run
//   busy, done            : run in progress / statistics final
//   n_total, n_correct    : accepted and exactly-correct sample counts
//   sum_ed, max_ed        : summed and largest error distance
//   worst_a, worst_b      : operands of the first sample that reached max_ed
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | after reset, waiting for start
// ST_RUN   | accepting samples, in_ready high
// ST_DRAIN | last sample accepted, pipeline emptying (down-counter)
// ST_DONE  | statistics final and stable until start or reset
module approx_err_monitor
    import approx_err_monitor_pkg::*;
#(
    parameter int unsigned W     = DEF_W,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          in_a,
    input  logic [W-1:0]          in_b,
    input  logic [2*W-1:0]        in_y,
    input  logic                  in_last,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      n_total,
    output logic [CNT_W-1:0]      n_correct,
    output logic [CNT_W+2*W-1:0]  sum_ed,
    output logic [2*W-1:0]        max_ed,
    output logic [W-1:0]          worst_a,
    output logic [W-1:0]          worst_b
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned SW = CNT_W + PW;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (&x) ? x : x + CNT_W'(1);
    endfunction

    function automatic logic [SW-1:0] sat_add(input logic [SW-1:0] x,
                                              input logic [PW-1:0] e);
        logic [SW:0] s;
        s = {1'b0, x} + {{(CNT_W + 1){1'b0}}, e};
        return s[SW] ? {SW{1'b1}} : s[SW-1:0];
    endfunction

    // ---------------- control FSM ----------------
    state_e     state_q, state_d;
    logic [1:0] drain_cnt_q, drain_cnt_d;
    logic       in_ready_q, in_ready_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic accept;
    logic clear;

    assign accept = in_valid && in_ready_q;
    assign clear  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (accept && in_last) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == 2'd0) state_d = ST_DONE;
                else                     drain_cnt_d = drain_cnt_q - 2'd1;
            end
            ST_DONE:  if (start) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
        // Outputs are registered from the next state so they change on the
        // same edge as the state itself.
        in_ready_d = (state_d == ST_RUN);
        busy_d     = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= 2'd0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // ---------------- stage 1: exact product and error distance ----------------
    logic [PW-1:0] exact_p;
    logic [PW-1:0] ed_now;

    exact_mult #(.W(W)) u_exact (
        .a (in_a),
        .b (in_b),
        .p (exact_p)
    );

    logic          s1_vld_q, s1_vld_d;
    logic [W-1:0]  s1_a_q, s1_a_d;
    logic [W-1:0]  s1_b_q, s1_b_d;
    logic [PW-1:0] s1_ed_q, s1_ed_d;

    always_comb begin
        ed_now   = (exact_p >= in_y) ? (exact_p - in_y) : (in_y - exact_p);
        s1_vld_d = accept;
        s1_a_d   = accept ? in_a   : s1_a_q;
        s1_b_d   = accept ? in_b   : s1_b_q;
        s1_ed_d  = accept ? ed_now : s1_ed_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_ed_q  <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s1_ed_q  <= s1_ed_d;
        end
    end

    // ---------------- stage 2: accumulators ----------------
    logic [CNT_W-1:0] acc_total_q, acc_total_d;
    logic [CNT_W-1:0] acc_correct_q, acc_correct_d;
    logic [SW-1:0]    acc_sum_q, acc_sum_d;
    logic [PW-1:0]    acc_max_q, acc_max_d;
    logic [W-1:0]     acc_wa_q, acc_wa_d;
    logic [W-1:0]     acc_wb_q, acc_wb_d;

    always_comb begin
        acc_total_d   = acc_total_q;
        acc_correct_d = acc_correct_q;
        acc_sum_d     = acc_sum_q;
        acc_max_d     = acc_max_q;
        acc_wa_d      = acc_wa_q;
        acc_wb_d      = acc_wb_q;
        if (clear) begin
            acc_total_d   = '0;
            acc_correct_d = '0;
            acc_sum_d     = '0;
            acc_max_d     = '0;
            acc_wa_d      = '0;
            acc_wb_d      = '0;
        end else if (s1_vld_q) begin
            acc_total_d = sat_inc(acc_total_q);
            if (s1_ed_q == '0) acc_correct_d = sat_inc(acc_correct_q);
            acc_sum_d = sat_add(acc_sum_q, s1_ed_q);
            // Strictly greater keeps the first sample on ties.
            if (s1_ed_q > acc_max_q) begin
                acc_max_d = s1_ed_q;
                acc_wa_d  = s1_a_q;
                acc_wb_d  = s1_b_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_total_q   <= '0;
            acc_correct_q <= '0;
            acc_sum_q     <= '0;
            acc_max_q     <= '0;
            acc_wa_q      <= '0;
            acc_wb_q      <= '0;
        end else begin
            acc_total_q   <= acc_total_d;
            acc_correct_q <= acc_correct_d;
            acc_sum_q     <= acc_sum_d;
            acc_max_q     <= acc_max_d;
            acc_wa_q      <= acc_wa_d;
            acc_wb_q      <= acc_wb_d;
        end
    end

    // ---------------- output registers ----------------
    // Published one edge after the accumulators so a sample's statistics
    // become visible together with done at the end of the drain.
    logic [CNT_W-1:0] n_total_q, n_total_d;
    logic [CNT_W-1:0] n_correct_q, n_correct_d;
    logic [SW-1:0]    sum_ed_q, sum_ed_d;
    logic [PW-1:0]    max_ed_q, max_ed_d;
    logic [W-1:0]     worst_a_q, worst_a_d;
    logic [W-1:0]     worst_b_q, worst_b_d;

    always_comb begin
        n_total_d   = clear ? '0 : acc_total_q;
        n_correct_d = clear ? '0 : acc_correct_q;
        sum_ed_d    = clear ? '0 : acc_sum_q;
        max_ed_d    = clear ? '0 : acc_max_q;
        worst_a_d   = clear ? '0 : acc_wa_q;
        worst_b_d   = clear ? '0 : acc_wb_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_total_q   <= '0;
            n_correct_q <= '0;
            sum_ed_q    <= '0;
            max_ed_q    <= '0;
            worst_a_q   <= '0;
            worst_b_q   <= '0;
        end else begin
            n_total_q   <= n_total_d;
            n_correct_q <= n_correct_d;
            sum_ed_q    <= sum_ed_d;
            max_ed_q    <= max_ed_d;
            worst_a_q   <= worst_a_d;
            worst_b_q   <= worst_b_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign n_total   = n_total_q;
    assign n_correct = n_correct_q;
    assign sum_ed    = sum_ed_q;
    assign max_ed    = max_ed_q;
    assign worst_a   = worst_a_q;
    assign worst_b   = worst_b_q;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Bench for approx_err_monitor: directed runs with a scoreboard of expected
// final statistics, plus a narrow-counter instance for saturation.
module tb_approx_err_monitor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main instance (W=4, CNT_W=16)
    logic        start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
    logic [3:0]  in_a = '0, in_b = '0;
    logic [7:0]  in_y = '0;
    logic        in_ready, busy, done;
    logic [15:0] n_total, n_correct;
    logic [23:0] sum_ed;
    logic [7:0]  max_ed;
    logic [3:0]  worst_a, worst_b;

    approx_err_monitor #(.W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_y(in_y),
        .in_last(in_last), .busy(busy), .done(done), .n_total(n_total),
        .n_correct(n_correct), .sum_ed(sum_ed), .max_ed(max_ed),
        .worst_a(worst_a), .worst_b(worst_b)
    );

    // saturation instance (CNT_W=4)
    logic        s_start = 1'b0, s_in_valid = 1'b0, s_in_last = 1'b0;
    logic [3:0]  s_in_a = '0, s_in_b = '0;
    logic [7:0]  s_in_y = '0;
    logic        s_in_ready, s_busy, s_done;
    logic [3:0]  s_n_total, s_n_correct;
    logic [11:0] s_sum_ed;
    logic [7:0]  s_max_ed;
    logic [3:0]  s_worst_a, s_worst_b;

    approx_err_monitor #(.W(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .in_a(s_in_a), .in_b(s_in_b), .in_y(s_in_y),
        .in_last(s_in_last), .busy(s_busy), .done(s_done), .n_total(s_n_total),
        .n_correct(s_n_correct), .sum_ed(s_sum_ed), .max_ed(s_max_ed),
        .worst_a(s_worst_a), .worst_b(s_worst_b)
    );

    typedef struct {
        longint unsigned tot;
        longint unsigned cor;
        longint unsigned sum;
        longint unsigned mx;
        longint unsigned wa;
        longint unsigned wb;
    } stats_t;

    stats_t m;
    stats_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        m = '{default: 0};
    endtask

    task automatic model_acc(input int a, input int b, input int y);
        int ex, ed;
        ex = a * b;
        ed = (ex >= y) ? ex - y : y - ex;
        if (m.tot < 65535) m.tot++;
        if (ed == 0 && m.cor < 65535) m.cor++;
        m.sum = m.sum + longint'(ed);
        if (longint'(ed) > m.mx) begin
            m.mx = longint'(ed);
            m.wa = longint'(a);
            m.wb = longint'(b);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offers one sample until accepted; returns cycles it was held off.
    task automatic send(input int a, input int b, input int y, input bit last,
                        output int stalls);
        bit acc;
        stalls   = 0;
        acc      = 1'b0;
        in_a     = 4'(a);
        in_b     = 4'(b);
        in_y     = 8'(y);
        in_last  = last;
        in_valid = 1'b1;
        while (!acc) begin
            acc = (in_ready === 1'b1);
            @(posedge clk); #1;
            if (!acc) begin
                stalls++;
                if (stalls > 50) begin
                    chk("accept_timeout", {63'd0, in_ready}, 64'd1);
                    break;
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (acc) begin
            model_acc(a, b, y);
            if (last) exp_q.push_back(m);
        end
    endtask

    task automatic wait_done(input string tag, output int cyc);
        stats_t e;
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_done"}, {63'd0, done}, 64'd1);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_ready"}, {63'd0, in_ready}, 64'd0);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_n_total"}, 64'(n_total), e.tot);
            chk({tag, "_n_correct"}, 64'(n_correct), e.cor);
            chk({tag, "_sum_ed"}, 64'(sum_ed), e.sum);
            chk({tag, "_max_ed"}, 64'(max_ed), e.mx);
            chk({tag, "_worst_a"}, 64'(worst_a), e.wa);
            chk({tag, "_worst_b"}, 64'(worst_b), e.wb);
        end else begin
            errors++;
            $error("FAIL %s_scoreboard: observed empty expected one entry", tag);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, {63'd0, in_ready}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_n_total"}, 64'(n_total), 64'd0);
        chk({tag, "_n_correct"}, 64'(n_correct), 64'd0);
        chk({tag, "_sum_ed"}, 64'(sum_ed), 64'd0);
        chk({tag, "_max_ed"}, 64'(max_ed), 64'd0);
        chk({tag, "_worst"}, {56'd0, worst_a, worst_b}, 64'd0);
    endtask

    initial begin
        int st, tot_st, cyc, gap, ex, ey;
        stats_t exh;

        // ---- reset ----
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check_all_zero("idle");

        // ---- single correct sample ----
        model_clear();
        pulse_start();
        chk("start_ready", {63'd0, in_ready}, 64'd1);
        chk("start_busy", {63'd0, busy}, 64'd1);
        send(3, 5, 15, 1'b1, st);
        chk("single_ready_drop", {63'd0, in_ready}, 64'd0);
        chk("single_busy_drain", {63'd0, busy}, 64'd1);
        wait_done("single", cyc);
        chk("single_done_latency", 64'(cyc), 64'd2);
        repeat (3) @(posedge clk);
        #1 chk("done_holds", {63'd0, done}, 64'd1);

        // ---- three samples with errors and a tie ----
        model_clear();
        pulse_start();
        chk("restart_done_low", {63'd0, done}, 64'd0);
        chk("restart_ready", {63'd0, in_ready}, 64'd1);
        chk("restart_cleared", 64'(n_total), 64'd0);
        send(15, 15, 209, 1'b0, st);
        send(7, 6, 42, 1'b0, st);
        send(12, 13, 140, 1'b1, st);
        wait_done("three", cyc);
        chk("three_sum_lit", 64'(sum_ed), 64'd32);
        chk("three_max_lit", 64'(max_ed), 64'd16);
        chk("three_worst_lit", {56'd0, worst_a, worst_b}, 64'hFF);

        // ---- exhaustive back-to-back ----
        model_clear();
        pulse_start();
        tot_st = 0;
        for (int i = 0; i < 256; i++) begin
            send(i / 16, i % 16, (i / 16) * (i % 16), i == 255, st);
            tot_st += st;
        end
        chk("exh_stalls", 64'(tot_st), 64'd0);
        exh = m;
        wait_done("exh", cyc);
        chk("exh_done_latency", 64'(cyc), 64'd2);
        chk("exh_total_lit", 64'(n_total), 64'd256);
        chk("exh_correct_lit", 64'(n_correct), 64'd256);

        // ---- random approximate products ----
        model_clear();
        pulse_start();
        for (int i = 0; i < 40; i++) begin
            ex = int'($urandom_range(0, 15));
            ey = int'($urandom_range(0, 15));
            send(ex, ey, (ex * ey) ^ int'($urandom_range(0, 7)), i == 39, st);
        end
        wait_done("rand", cyc);

        // ---- exhaustive with stalls and a mid-run start ----
        model_clear();
        pulse_start();
        for (int i = 0; i < 256; i++) begin
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
            if (i == 100) begin
                pulse_start();
                chk("midrun_start_busy", {63'd0, busy}, 64'd1);
                chk("midrun_start_ready", {63'd0, in_ready}, 64'd1);
            end
            send(i / 16, i % 16, (i / 16) * (i % 16), i == 255, st);
        end
        wait_done("stall", cyc);
        chk("stall_vs_exh_total", 64'(n_total), exh.tot);
        chk("stall_vs_exh_sum", 64'(sum_ed), exh.sum);

        // ---- reset during drain ----
        model_clear();
        pulse_start();
        send(9, 9, 80, 1'b1, st);
        chk("drain_busy", {63'd0, busy}, 64'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_all_zero("post_reset_idle");
        model_clear();
        pulse_start();
        send(10, 11, 110, 1'b1, st);
        wait_done("after_reset", cyc);

        // ---- saturation on narrow counters ----
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk("sat_ready", {63'd0, s_in_ready}, 64'd1);
            s_in_valid = 1'b1;
            s_in_a     = 4'(i % 16);
            s_in_b     = 4'd2;
            s_in_y     = 8'((i % 16) * 2);
            s_in_last  = (i == 19);
            @(posedge clk); #1;
        end
        s_in_valid = 1'b0;
        s_in_last  = 1'b0;
        cyc = 0;
        while (s_done !== 1'b1 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("sat_done", {63'd0, s_done}, 64'd1);
        chk("sat_n_total", 64'(s_n_total), 64'd15);
        chk("sat_n_correct", 64'(s_n_correct), 64'd15);
        chk("sat_sum_ed", 64'(s_sum_ed), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
